// File: rtl/dir_cmd_queue.sv
// -----------------------------------------------------------------------------
// dir_cmd_queue
//
// Upstream command stage for the snake game logic. Raw NEC codes arrive from
// the IR decoder with a toggle handshake. Each new code is classified as a
// turn, a pause request, or noise. Turns that are neither repeats nor
// reversals of the most recent heading are buffered in a small FIFO. The FIFO
// releases one turn per game tick, so quick multi-key input is not lost.
//
// Ports
//   game_clk     in   1    game tick clock, one snake step per rising edge
//   reset_n      in   1    asynchronous, active-low reset
//   ir_code      in   32   last decoded IR code, stable around each toggle
//   ir_toggle    in   1    flips once per new code (asynchronous domain)
//   game_over    in   1    level from game logic: flush, clear, ignore input
//   direction    out  32   NEC code of current heading, 32'h0 = hold still
//   paused       out  1    pause state
//   queue_count  out  clog2(DEPTH)+1   FIFO occupancy
//   dropped      out  1    one-cycle pulse when a valid turn hits a full FIFO
// -----------------------------------------------------------------------------
module dir_cmd_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] UP_CODE    = 32'h20DF6A95,
    parameter logic [31:0] DOWN_CODE  = 32'h20DFEA15,
    parameter logic [31:0] LEFT_CODE  = 32'h20DF1AE5,
    parameter logic [31:0] RIGHT_CODE = 32'h20DF9A65,
    parameter logic [31:0] PAUSE_CODE = 32'h20DF22DD
) (
    input  logic                       game_clk,
    input  logic                       reset_n,
    input  logic [31:0]                ir_code,
    input  logic                       ir_toggle,
    input  logic                       game_over,
    output logic [31:0]                direction,
    output logic                       paused,
    output logic [$clog2(DEPTH):0]     queue_count,
    output logic                       dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Opposite directions differ only in bit 0, so a reversal is ref ^ 2'b01.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    function automatic logic [31:0] dir_code(input logic [1:0] d);
        case (d)
            DIR_UP:   dir_code = UP_CODE;
            DIR_DOWN: dir_code = DOWN_CODE;
            DIR_LEFT: dir_code = LEFT_CODE;
            default:  dir_code = RIGHT_CODE;
        endcase
    endfunction

    // Flops
    logic          s1_q, s2_q, s3_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    dir_reg_q, dir_reg_d;
    logic          dir_valid_q, dir_valid_d;   // 0 = no heading yet
    logic          paused_q, paused_d;
    logic          dropped_q, dropped_d;
    logic [31:0]   direction_q, direction_d;
    logic [1:0]    fifo_mem [DEPTH];

    // Combinational helpers
    logic          ir_event;
    logic          is_dir, is_pause;
    logic [1:0]    cand;
    logic [1:0]    ref_dir;
    logic          ref_valid;
    logic          accept, push, pop, full;
    logic [AW-1:0] newest_ptr;

    assign ir_event   = s2_q ^ s3_q;
    assign newest_ptr = wr_ptr_q - 1'b1;
    assign full       = (count_q == CW'(DEPTH));

    always_comb begin
        is_dir   = 1'b1;
        is_pause = 1'b0;
        cand     = DIR_UP;
        if (ir_code == UP_CODE)         cand = DIR_UP;
        else if (ir_code == DOWN_CODE)  cand = DIR_DOWN;
        else if (ir_code == LEFT_CODE)  cand = DIR_LEFT;
        else if (ir_code == RIGHT_CODE) cand = DIR_RIGHT;
        else begin
            is_dir   = 1'b0;
            is_pause = (ir_code == PAUSE_CODE);
        end
    end

    always_comb begin
        // Turns are validated against the newest queued heading, so a burst
        // of keys is checked as a chain rather than against the stale head.
        ref_valid = (count_q != '0) || dir_valid_q;
        ref_dir   = (count_q != '0) ? fifo_mem[newest_ptr] : dir_reg_q;

        accept = ir_event && !game_over && is_dir &&
                 (!ref_valid || ((cand != ref_dir) && (cand != (ref_dir ^ 2'b01))));
        pop    = !paused_q && !game_over && (count_q != '0);
        // A pop in the same edge frees the slot, so a full FIFO still accepts.
        push   = accept && (!full || pop);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dir_reg_d   = dir_reg_q;
        dir_valid_d = dir_valid_q;
        paused_d    = paused_q;
        dropped_d   = accept && full && !pop;

        if (game_over) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            dir_valid_d = 1'b0;
            dir_reg_d   = DIR_UP;
            paused_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                dir_reg_d   = fifo_mem[rd_ptr_q];
                dir_valid_d = 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (ir_event && is_pause) paused_d = !paused_q;
        end

        // Output is computed from next state so it changes on the pop edge.
        if (paused_d || game_over || !dir_valid_d) direction_d = 32'h0;
        else                                       direction_d = dir_code(dir_reg_d);
    end

    always_ff @(posedge game_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dir_reg_q   <= DIR_UP;
            dir_valid_q <= 1'b0;
            paused_q    <= 1'b0;
            dropped_q   <= 1'b0;
            direction_q <= 32'h0;
        end else begin
            s1_q        <= ir_toggle;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dir_reg_q   <= dir_reg_d;
            dir_valid_q <= dir_valid_d;
            paused_q    <= paused_d;
            dropped_q   <= dropped_d;
            direction_q <= direction_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge game_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= cand;
    end

    assign direction   = direction_q;
    assign paused      = paused_q;
    assign queue_count = count_q;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_dir_cmd_queue.sv
module tb_dir_cmd_queue;

    localparam logic [31:0] UP    = 32'h20DF6A95;
    localparam logic [31:0] DOWN  = 32'h20DFEA15;
    localparam logic [31:0] LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] RIGHT = 32'h20DF9A65;
    localparam logic [31:0] PAUSE = 32'h20DF22DD;
    localparam logic [31:0] JUNK  = 32'h12345678;

    logic        game_clk = 1'b0;
    logic        reset_n;
    logic [31:0] ir_code;
    logic        ir_toggle;
    logic        game_over;
    logic [31:0] direction;
    logic        paused;
    logic [2:0]  queue_count;
    logic        dropped;

    int total = 0;
    int bad   = 0;
    int drops = 0;

    always #5 game_clk = ~game_clk;

    dir_cmd_queue dut (
        .game_clk    (game_clk),
        .reset_n     (reset_n),
        .ir_code     (ir_code),
        .ir_toggle   (ir_toggle),
        .game_over   (game_over),
        .direction   (direction),
        .paused      (paused),
        .queue_count (queue_count),
        .dropped     (dropped)
    );

    typedef struct {
        logic [31:0] code;
        logic [31:0] exp_dir;
        int          exp_cnt;
        logic        exp_paused;
        int          exp_drops;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and tally dropped pulses.
    task automatic tick();
        @(posedge game_clk);
        #1;
        if (dropped === 1'b1) drops++;
    endtask

    task automatic send(input logic [31:0] code);
        ir_code   = code;
        ir_toggle = ~ir_toggle;
    endtask

    task automatic send_wait(input logic [31:0] code);
        send(code);
        repeat (6) tick();
    endtask

    initial begin
        logic [31:0] pop_seq [4];

        // dir starts RIGHT after the latency sequence
        vecs[0]  = '{LEFT,  RIGHT, 0, 1'b0, 0};  // reversal
        vecs[1]  = '{RIGHT, RIGHT, 0, 1'b0, 0};  // repeat
        vecs[2]  = '{UP,    UP,    0, 1'b0, 0};
        vecs[3]  = '{LEFT,  LEFT,  0, 1'b0, 0};
        vecs[4]  = '{DOWN,  DOWN,  0, 1'b0, 0};
        vecs[5]  = '{JUNK,  DOWN,  0, 1'b0, 0};  // unknown code
        vecs[6]  = '{UP,    DOWN,  0, 1'b0, 0};  // reversal of DOWN
        vecs[7]  = '{RIGHT, RIGHT, 0, 1'b0, 0};
        vecs[8]  = '{PAUSE, 32'h0, 0, 1'b1, 0};
        vecs[9]  = '{UP,    32'h0, 1, 1'b1, 0};
        vecs[10] = '{LEFT,  32'h0, 2, 1'b1, 0};
        vecs[11] = '{DOWN,  32'h0, 3, 1'b1, 0};
        vecs[12] = '{RIGHT, 32'h0, 4, 1'b1, 0};
        vecs[13] = '{UP,    32'h0, 4, 1'b1, 1};  // full -> dropped
        vecs[14] = '{DOWN,  32'h0, 4, 1'b1, 1};  // checked vs newest RIGHT, full

        pop_seq[0] = UP;
        pop_seq[1] = LEFT;
        pop_seq[2] = DOWN;
        pop_seq[3] = RIGHT;

        reset_n   = 1'b0;
        ir_toggle = 1'b0;
        ir_code   = 32'h0;
        game_over = 1'b0;
        #12;
        chk("reset_direction", direction, 32'h0);
        chk("reset_count", 32'(queue_count), 32'd0);
        chk("reset_paused", 32'(paused), 32'd0);
        chk("reset_dropped", 32'(dropped), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // First turn: direction appears 3 edges after the first sampling edge
        send(RIGHT);
        tick();
        chk("lat_k0_dir", direction, 32'h0);
        tick();
        chk("lat_k1_dir", direction, 32'h0);
        tick();
        chk("lat_k2_dir", direction, 32'h0);
        chk("lat_k2_cnt", 32'(queue_count), 32'd1);
        tick();
        chk("lat_k3_dir", direction, RIGHT);
        chk("lat_k3_cnt", 32'(queue_count), 32'd0);
        $display("txn latency dir=%h cnt=%0d", direction, queue_count);
        repeat (3) tick();

        for (int i = 0; i < NV; i++) begin
            drops = 0;
            send_wait(vecs[i].code);
            $display("txn vec%0d code=%h dir=%h cnt=%0d paused=%0d drops=%0d",
                     i, vecs[i].code, direction, queue_count, paused, drops);
            chk($sformatf("vec%0d_dir", i), direction, vecs[i].exp_dir);
            chk($sformatf("vec%0d_cnt", i), 32'(queue_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_paused", i), 32'(paused), 32'(vecs[i].exp_paused));
            chk($sformatf("vec%0d_drops", i), 32'(drops), 32'(vecs[i].exp_drops));
        end

        // Unpause: four pops on consecutive edges
        send(PAUSE);
        repeat (3) tick();
        chk("unpause_paused", 32'(paused), 32'd0);
        chk("unpause_cnt", 32'(queue_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("txn pop%0d dir=%h cnt=%0d", i, direction, queue_count);
            chk($sformatf("pop%0d_dir", i), direction, pop_seq[i]);
            chk($sformatf("pop%0d_cnt", i), 32'(queue_count), 32'(3 - i));
        end
        repeat (2) tick();

        // game_over flush with three queued entries
        send_wait(PAUSE);
        send_wait(UP);
        send_wait(LEFT);
        send_wait(DOWN);
        chk("go_pre_cnt", 32'(queue_count), 32'd3);
        game_over = 1'b1;
        tick();
        $display("txn game_over dir=%h cnt=%0d paused=%0d", direction, queue_count, paused);
        chk("go_cnt", 32'(queue_count), 32'd0);
        chk("go_dir", direction, 32'h0);
        chk("go_paused", 32'(paused), 32'd0);
        send_wait(UP);
        chk("go_ign_cnt", 32'(queue_count), 32'd0);
        chk("go_ign_dir", direction, 32'h0);
        send_wait(PAUSE);
        chk("go_ign_pause", 32'(paused), 32'd0);
        game_over = 1'b0;
        repeat (2) tick();
        // LEFT would be a reversal of the old RIGHT heading if it survived
        send_wait(LEFT);
        chk("post_go_left", direction, LEFT);
        send_wait(DOWN);
        $display("txn post_game_over dir=%h", direction);
        chk("post_go_down", direction, DOWN);

        // Reset while an event sits between sync and enqueue
        send(RIGHT);
        repeat (2) tick();
        #2;
        reset_n   = 1'b0;
        ir_toggle = 1'b0;
        #1;
        chk("rst_mid_dir", direction, 32'h0);
        chk("rst_mid_cnt", 32'(queue_count), 32'd0);
        chk("rst_mid_paused", 32'(paused), 32'd0);
        chk("rst_mid_dropped", 32'(dropped), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rst_stale%0d_cnt", i), 32'(queue_count), 32'd0);
        end
        chk("rst_stale_dir", direction, 32'h0);
        send_wait(UP);
        $display("txn after_reset dir=%h cnt=%0d", direction, queue_count);
        chk("rst_resume_dir", direction, UP);
        chk("rst_drops", 32'(drops), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
